debounce_multi: RTL and testbench
=================================

Name: debounce_multi

Overview:
- Parametrised multi-channel push-button conditioner; successor to the single-channel 1 ms debouncer.
- Per channel:
  - 2-FF synchroniser
  - optional input inversion
  - debounce time programmable in ticks
  - clean level output
  - one-cycle press and release pulses
  - long-press detection with auto-repeat
- All channels share one tick prescaler.
- Sits between board buttons and the clock/setting control FSMs.

Parameters:
- N_CH, 4, number of independent button channels (>=1).
- TICK_CYCLES, 100000, ck cycles per tick (1 ms at 100 MHz); >=2.
- DEB_TICKS, 5, ticks the input must differ continuously from the debounced level before that level flips; >=1.
- HOLD_TICKS, 1000, ticks of debounced press before the hold pulse; >=1.
- REPEAT_TICKS, 200, tick period of repeat pulses after hold; 0 disables repeat.
- INVERT, {N_CH{1'b0}}, per-channel bit; 1 means the input is active-low and is inverted before the synchroniser.

Ports:
- ck  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- button  in  N_CH  raw asynchronous button inputs.
- button_deb  out  N_CH  debounced level, 1 = pressed.
- press  out  N_CH  one-cycle pulse on debounced rise.
- release  out  N_CH  one-cycle pulse on debounced fall.
- hold  out  N_CH  one-cycle pulse when the hold threshold is reached.
- held  out  N_CH  level; 1 from the hold pulse until release.
- repeat  out  N_CH  one-cycle pulse every REPEAT_TICKS ticks while held.
- tick  out  1  prescaler strobe, for monitoring and for reuse by neighbouring blocks.

Behaviour:
- One clock, ck. Reset is synchronous and active-high, on port reset; it wins over every other event in the same cycle.
- Reset values: all outputs 0; prescaler, sync FFs, and all per-channel counters 0.
- Prescaler:
  - pc counts 0..TICK_CYCLES-1 and wraps.
  - tick = 1 (registered) in the cycle where pc == TICK_CYCLES-1.
  - Width is $clog2(TICK_CYCLES).
- Synchroniser: s[i] = button[i] XOR INVERT[i], passed through 2 FFs. Latency is 2 cycles.
- Debounce counter dc[i], width $clog2(DEB_TICKS+1):
  - Any cycle with sync == button_deb: dc <= 0, independent of tick.
  - tick=1 and sync != button_deb:
    - If dc == DEB_TICKS-1: button_deb <= sync, dc <= 0.
    - Else: dc <= dc+1.
  - Any single-cycle return of sync to the current level restarts the count (no partial credit).
- press[i] and release[i] are registered on the same edge that button_deb[i] changes, high for exactly 1 cycle. Both can never be high together on one channel.
- Latency, input edge to press: 2 + (DEB_TICKS-1)*TICK_CYCLES + 1 cycles minimum, 2 + DEB_TICKS*TICK_CYCLES cycles maximum.
- Hold counter hc[i], saturating at HOLD_TICKS, and repeat counter rc[i]:
  - Cleared whenever button_deb == 0, including on the release edge, which also clears held.
  - tick=1, button_deb=1, held=0: if hc == HOLD_TICKS-1, pulse hold, set held, rc <= 0; else hc <= hc+1.
  - tick=1, held=1, REPEAT_TICKS != 0: if rc == REPEAT_TICKS-1, pulse repeat, rc <= 0; else rc <= rc+1.
  - The tick on which press occurs does not count toward hold.
  - hold and repeat never pulse in the same cycle.
- Channels are fully independent; a simultaneous press on several channels produces simultaneous pulses.
- Reset mid-press: outputs drop to 0 on that edge. If the input is still active after reset, the channel re-debounces from scratch and produces a fresh press.
- There is no counter overflow or wrap beyond the ranges above.

Test Plan:
All scenarios use TICK_CYCLES=4, DEB_TICKS=3, HOLD_TICKS=5, REPEAT_TICKS=2, N_CH=2.
- Clean press: button[0] rises and is held → press[0] is a single-cycle pulse 11–14 cycles after the edge, and button_deb[0]=1 from that edge. Channel 1 outputs stay 0.
- Bounce rejection: button[0] toggles every 3 cycles for 40 cycles, then settles low → press, release, and button_deb stay 0 throughout.
- Long press and repeat: button[0] held for 60 cycles after press → hold[0] and held[0] assert 20 cycles after press. repeat[0] pulses 8, 16, 24 cycles after hold. On release, release[0] pulses 11–14 cycles after the falling input and held[0] clears on the same edge.
- Active-low channel: INVERT=2'b10, button[1] idle high then driven low → press[1] appears within 11–14 cycles. No pulse during the reset-to-idle period.
- Reset mid-hold: assert reset for 1 cycle while held[0]=1 with the button still pressed → all outputs 0 the next cycle. press[0] recurs 11–14 cycles after reset release. hold[0] recurs 20 cycles after that press.
- Simultaneous channels: both buttons rise on the same cycle → press[1:0]=2'b11 on the same edge, and tick has period exactly 4.

Source files
------------

// File: rtl/debounce_multi.sv
// Multi-channel push-button conditioner: synchroniser, tick-based debounce,
// press/release pulses and long-press hold with auto-repeat, sharing one tick prescaler.
module debounce_multi #(
    parameter int              N_CH         = 4,
    parameter int              TICK_CYCLES  = 100000,
    parameter int              DEB_TICKS    = 5,
    parameter int              HOLD_TICKS   = 1000,
    parameter int              REPEAT_TICKS = 200,
    parameter logic [N_CH-1:0] INVERT       = {N_CH{1'b0}}
) (
    input  logic            ck,
    input  logic            reset,
    input  logic [N_CH-1:0] button,
    output logic [N_CH-1:0] button_deb,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] hold,
    output logic [N_CH-1:0] held,
    output logic [N_CH-1:0] repeat_pulse,
    output logic            tick
);

    localparam int PC_W = $clog2(TICK_CYCLES);
    localparam int DC_W = $clog2(DEB_TICKS + 1);
    localparam int HC_W = $clog2(HOLD_TICKS + 1);
    localparam int RC_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(TICK_CYCLES - 1);
    localparam logic [PC_W-1:0] PC_PRE  = PC_W'(TICK_CYCLES - 2);
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEB_TICKS - 1);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_TICKS - 1);
    localparam logic [HC_W-1:0] HC_SAT  = HC_W'(HOLD_TICKS);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);
    localparam bit              REPEAT_EN = (REPEAT_TICKS != 0);

    logic [PC_W-1:0] pc;
    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;
    logic [N_CH-1:0] deb_fall;
    logic [DC_W-1:0] dc [N_CH];
    logic [HC_W-1:0] hc [N_CH];
    logic [RC_W-1:0] rc [N_CH];

    // tick is registered one cycle early so it is high exactly while pc sits at its last value
    always_ff @(posedge ck) begin
        if (reset) begin
            pc   <= '0;
            tick <= 1'b0;
        end else begin
            pc   <= (pc == PC_LAST) ? '0 : pc + 1'b1;
            tick <= (pc == PC_PRE);
        end
    end

    always_ff @(posedge ck) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= button ^ INVERT;
            sync2 <= sync1;
        end
    end

    always_comb begin
        deb_fall = '0;
        for (int i = 0; i < N_CH; i++) begin
            deb_fall[i] = tick && button_deb[i] && !sync2[i] && (dc[i] == DC_LAST);
        end
    end

    // Hold/repeat counting is cleared on the release edge itself, so held drops with button_deb
    always_ff @(posedge ck) begin
        if (reset) begin
            button_deb    <= '0;
            press         <= '0;
            release_pulse <= '0;
            hold          <= '0;
            held          <= '0;
            repeat_pulse  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                dc[i] <= '0;
                hc[i] <= '0;
                rc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                press[i]         <= 1'b0;
                release_pulse[i] <= 1'b0;
                hold[i]          <= 1'b0;
                repeat_pulse[i]  <= 1'b0;

                if (sync2[i] == button_deb[i]) begin
                    dc[i] <= '0;
                end else if (tick) begin
                    if (dc[i] == DC_LAST) begin
                        button_deb[i]    <= sync2[i];
                        dc[i]            <= '0;
                        press[i]         <= sync2[i];
                        release_pulse[i] <= !sync2[i];
                    end else begin
                        dc[i] <= dc[i] + 1'b1;
                    end
                end

                if (!button_deb[i] || deb_fall[i]) begin
                    hc[i]   <= '0;
                    rc[i]   <= '0;
                    held[i] <= 1'b0;
                end else if (tick) begin
                    if (!held[i]) begin
                        if (hc[i] == HC_LAST) begin
                            hold[i] <= 1'b1;
                            held[i] <= 1'b1;
                            hc[i]   <= HC_SAT;
                            rc[i]   <= '0;
                        end else begin
                            hc[i] <= hc[i] + 1'b1;
                        end
                    end else if (REPEAT_EN) begin
                        if (rc[i] == RC_LAST) begin
                            repeat_pulse[i] <= 1'b1;
                            rc[i]           <= '0;
                        end else begin
                            rc[i] <= rc[i] + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi with small timing parameters; channel 1 is active-low.
module tb_debounce_multi;

    localparam int N_CH = 2;

    logic            ck = 1'b0;
    logic            reset;
    logic [N_CH-1:0] button;
    logic [N_CH-1:0] button_deb;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] hold;
    logic [N_CH-1:0] held;
    logic [N_CH-1:0] repeat_pulse;
    logic            tick;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  c0, t, tp, th, t1, t2, t3;
    int  nrep;
    int  rep_t [3];
    bit  found;

    debounce_multi #(
        .N_CH(N_CH), .TICK_CYCLES(4), .DEB_TICKS(3), .HOLD_TICKS(5),
        .REPEAT_TICKS(2), .INVERT(2'b10)
    ) dut (
        .ck(ck), .reset(reset), .button(button), .button_deb(button_deb),
        .press(press), .release_pulse(release_pulse), .hold(hold), .held(held),
        .repeat_pulse(repeat_pulse), .tick(tick)
    );

    always #5 ck = ~ck;
    always @(posedge ck) cyc <= cyc + 1;

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        button = 2'b10;
        repeat (3) step();
        checks++;
        if ({button_deb, press, release_pulse, hold, held, repeat_pulse, tick} !== 13'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %b, want all zero",
                     {button_deb, press, release_pulse, hold, held, repeat_pulse, tick});
        end
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if ({button_deb, press, release_pulse} !== 6'b0) begin
                errors++;
                $display("[TB] FAIL idle_after_reset cycle %0d: got deb/press/rel %b, want 0", k,
                         {button_deb, press, release_pulse});
            end
        end
    endtask

    task automatic test_clean_press();
        c0 = cyc; t = -1; found = 0;
        button[0] = 1'b1;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (press[0]) begin found = 1; t = cyc - c0; end
        end
        checks++;
        if (!found || t < 11 || t > 14) begin
            errors++;
            $display("[TB] FAIL clean_press_latency: got %0d, want 11..14", t);
        end
        checks++;
        if (button_deb !== 2'b01 || press !== 2'b01) begin
            errors++;
            $display("[TB] FAIL clean_press_levels: got deb %b press %b, want 01 01", button_deb, press);
        end
        step();
        checks++;
        if (press[0] !== 1'b0 || button_deb[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clean_press_single: got press %b deb %b, want 0 1", press[0], button_deb[0]);
        end
        checks++;
        if ({button_deb[1], press[1], release_pulse[1], hold[1], held[1], repeat_pulse[1]} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL clean_press_ch1_quiet: got %b, want 000000",
                     {button_deb[1], press[1], release_pulse[1], hold[1], held[1], repeat_pulse[1]});
        end
        c0 = cyc; t = -1; found = 0;
        button[0] = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (release_pulse[0]) begin found = 1; t = cyc - c0; end
        end
        checks++;
        if (!found || t < 11 || t > 14 || button_deb[0] !== 1'b0 || held[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clean_release: got latency %0d deb %b held %b, want 11..14 0 0",
                     t, button_deb[0], held[0]);
        end
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 60; k++) begin
            if (k < 40 && k % 3 == 0) button[0] = ~button[0];
            if (k == 40) button[0] = 1'b0;
            step();
            checks++;
            if (press[0] !== 1'b0 || release_pulse[0] !== 1'b0 || button_deb[0] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bounce cycle %0d: got press %b rel %b deb %b, want 0 0 0",
                         k, press[0], release_pulse[0], button_deb[0]);
            end
        end
    endtask

    task automatic test_long_press();
        found = 0; tp = -1;
        button[0] = 1'b1;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (press[0]) begin found = 1; tp = cyc; end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL long_press_press: got no press, want press within 20 cycles");
        end
        found = 0; th = -1;
        for (int k = 0; k < 30 && !found; k++) begin
            step();
            if (hold[0]) begin found = 1; th = cyc; end
        end
        checks++;
        if (!found || th - tp != 20 || held[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_timing: got %0d cycles after press held %b, want 20 1", th - tp, held[0]);
        end
        nrep = 0;
        for (int k = 0; k < 26; k++) begin
            step();
            if (hold[0] && repeat_pulse[0]) begin
                errors++;
                $display("[TB] FAIL hold_repeat_overlap: got both high, want exclusive");
            end
            if (repeat_pulse[0] && nrep < 3) begin rep_t[nrep] = cyc - th; nrep++; end
        end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (j >= nrep || rep_t[j] != 8 * (j + 1)) begin
                errors++;
                $display("[TB] FAIL repeat_%0d: got %0d, want %0d", j, (j < nrep) ? rep_t[j] : -1, 8 * (j + 1));
            end
        end
        c0 = cyc; t = -1; found = 0;
        button[0] = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (release_pulse[0]) begin found = 1; t = cyc - c0; end
        end
        checks++;
        if (!found || t < 11 || t > 14 || held[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL long_release: got latency %0d held %b, want 11..14 0", t, held[0]);
        end
    endtask

    task automatic test_active_low();
        c0 = cyc; t = -1; found = 0;
        button[1] = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (press[1]) begin found = 1; t = cyc - c0; end
        end
        checks++;
        if (!found || t < 11 || t > 14 || button_deb !== 2'b10 || press[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL active_low_press: got latency %0d deb %b, want 11..14 10", t, button_deb);
        end
        c0 = cyc; t = -1; found = 0;
        button[1] = 1'b1;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (release_pulse[1]) begin found = 1; t = cyc - c0; end
        end
        checks++;
        if (!found || t < 11 || t > 14 || button_deb[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL active_low_release: got latency %0d deb %b, want 11..14 0", t, button_deb[1]);
        end
    endtask

    task automatic test_reset_mid_hold();
        found = 0;
        button[0] = 1'b1;
        for (int k = 0; k < 45 && !found; k++) begin
            step();
            if (hold[0]) found = 1;
        end
        checks++;
        if (!found || held[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_hold_setup: got held %b, want 1", held[0]);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({button_deb, press, release_pulse, hold, held, repeat_pulse, tick} !== 13'b0) begin
            errors++;
            $display("[TB] FAIL mid_hold_reset: got %b, want all zero",
                     {button_deb, press, release_pulse, hold, held, repeat_pulse, tick});
        end
        c0 = cyc; tp = -1; found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (press[0]) begin found = 1; tp = cyc; end
        end
        checks++;
        if (!found || tp - c0 < 11 || tp - c0 > 14) begin
            errors++;
            $display("[TB] FAIL re_press: got %0d cycles after reset, want 11..14", tp - c0);
        end
        found = 0; th = -1;
        for (int k = 0; k < 30 && !found; k++) begin
            step();
            if (hold[0]) begin found = 1; th = cyc; end
        end
        checks++;
        if (!found || th - tp != 20) begin
            errors++;
            $display("[TB] FAIL re_hold: got %0d cycles after press, want 20", th - tp);
        end
        button[0] = 1'b0;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (release_pulse[0]) found = 1;
        end
    endtask

    task automatic test_simultaneous();
        found = 0;
        button = 2'b01;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (press !== 2'b00) found = 1;
        end
        checks++;
        if (press !== 2'b11 || button_deb !== 2'b11) begin
            errors++;
            $display("[TB] FAIL simultaneous_press: got press %b deb %b, want 11 11", press, button_deb);
        end
        t1 = -1; t2 = -1; t3 = -1;
        for (int k = 0; k < 16; k++) begin
            step();
            if (tick) begin
                if (t1 < 0) t1 = cyc;
                else if (t2 < 0) t2 = cyc;
                else if (t3 < 0) t3 = cyc;
            end
        end
        checks++;
        if (t3 < 0 || t2 - t1 != 4 || t3 - t2 != 4) begin
            errors++;
            $display("[TB] FAIL tick_period: got %0d and %0d, want 4 and 4", t2 - t1, t3 - t2);
        end
        found = 0;
        button = 2'b10;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (release_pulse !== 2'b00) found = 1;
        end
        checks++;
        if (release_pulse !== 2'b11 || button_deb !== 2'b00) begin
            errors++;
            $display("[TB] FAIL simultaneous_release: got rel %b deb %b, want 11 00", release_pulse, button_deb);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_active_low();
        test_reset_mid_hold();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
